// File: rtl/lane_rr_arbiter_if.sv
// Bundle of request, release, data and grant signals shared between the
// requesters and the round-robin lane arbiter.
interface lane_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] last;
  logic [N_REQ-1:0] din;
  logic [N_REQ-1:0] gnt;
  logic             o;
  logic             o_vld;
  logic             busy;
  logic             timeout;

  modport master (
    output req, last, din,
    input  gnt, o, o_vld, busy, timeout
  );

  modport slave (
    input  req, last, din,
    output gnt, o, o_vld, busy, timeout
  );
endinterface

// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter that hands a 1-bit output lane to one requester at a
// time, with per-ownership hold limit and back-to-back handover on release.
module lane_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  lane_rr_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    owner_reg, owner_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [HW-1:0]    hold_reg, hold_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic             o_reg, o_next;
  logic             o_vld_reg, o_vld_next;
  logic             timeout_reg, timeout_next;

  logic             own_last, own_req, hold_hit, release_now;
  logic [PW-1:0]    owner_inc, search_ptr, win_idx;
  logic             win_any;
  logic [PW-1:0]    rot_idx [N_REQ];
  logic [N_REQ-1:0] rot_req;

  assign own_last    = bus.last[owner_reg];
  assign own_req     = bus.req[owner_reg];
  assign hold_hit    = (hold_reg == HW'(HOLD_MAX));
  assign release_now = (state_reg == OWN) && (own_last || !own_req || hold_hit);
  assign owner_inc   = (owner_reg == PW'(N_REQ - 1)) ? '0 : owner_reg + PW'(1);

  // On a release the search already starts after the releasing owner.
  assign search_ptr  = release_now ? owner_inc : ptr_reg;

  // rot_req[gi] is the request of the requester gi places after search_ptr.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [PW:0] sum;
      assign sum         = {1'b0, search_ptr} + (PW+1)'(gi);
      assign rot_idx[gi] = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ))
                                                   : sum[PW-1:0];
      assign rot_req[gi] = bus.req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) win_idx = rot_idx[i];
    end
  end
  assign win_any = |rot_req;

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    timeout_next = 1'b0;
    gnt_next     = '0;
    o_next       = 1'b0;
    o_vld_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (win_any) begin
          state_next = OWN;
          owner_next = win_idx;
          hold_next  = HW'(1);
        end
      end
      OWN: begin
        o_next     = bus.din[owner_reg];
        o_vld_next = 1'b1;
        if (release_now) begin
          ptr_next     = owner_inc;
          // A coincident last or a dropped request makes it a normal release.
          timeout_next = hold_hit && !own_last && own_req;
          if (win_any) begin
            owner_next = win_idx;
            hold_next  = HW'(1);
          end else begin
            state_next = IDLE;
            hold_next  = '0;
          end
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == OWN) gnt_next[owner_next] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      ptr_reg     <= '0;
      hold_reg    <= '0;
      gnt_reg     <= '0;
      o_reg       <= 1'b0;
      o_vld_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
      gnt_reg     <= gnt_next;
      o_reg       <= o_next;
      o_vld_reg   <= o_vld_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.o       = o_reg;
  assign bus.o_vld   = o_vld_reg;
  assign bus.busy    = (state_reg == OWN);
  assign bus.timeout = timeout_reg;
endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Self-checking bench for lane_rr_arbiter: directed vector table, multi-cycle
// sequences, and randomized traffic against a behavioural reference model.
module tb_lane_rr_arbiter;
  localparam int N  = 4;
  localparam int HM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lane_rr_arbiter_if #(.N_REQ(N)) bus();

  lane_rr_arbiter #(.N_REQ(N), .HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit       rst_n;
    bit [3:0] req;
    bit [3:0] last;
    bit [3:0] din;
    bit [3:0] gnt;
    bit       o;
    bit       vld;
    bit       busy;
    bit       to;
  } vec_t;

  vec_t tbl [24];
  int   n_tbl = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state: owner index (-1 = none), pointer, hold count
  int       m_owner = -1;
  int       m_ptr = 0;
  int       m_hold = 0;
  bit [3:0] e_gnt = '0;
  bit       e_o = 0, e_vld = 0, e_to = 0;

  function automatic int pick(input bit [3:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit rel;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
      e_o = 0; e_vld = 0; e_to = 0;
    end else begin
      e_o   = (m_owner >= 0) ? bus.din[m_owner] : 1'b0;
      e_vld = (m_owner >= 0);
      e_to  = 0;
      if (m_owner < 0) begin
        m_owner = pick(bus.req, m_ptr);
        m_hold  = (m_owner >= 0) ? 1 : 0;
      end else begin
        rel = bus.last[m_owner] || !bus.req[m_owner] || (m_hold == HM);
        if (rel) begin
          e_to    = (m_hold == HM) && !bus.last[m_owner] && bus.req[m_owner];
          m_ptr   = (m_owner + 1) % N;
          m_owner = pick(bus.req, m_ptr);
          m_hold  = (m_owner >= 0) ? 1 : 0;
        end else begin
          m_hold++;
        end
      end
    end
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%b want=%b ({gnt,o,vld,busy,to})", name, idx, act, exp);
  endtask

  function automatic logic [7:0] dut_out();
    return {bus.gnt, bus.o, bus.o_vld, bus.busy, bus.timeout};
  endfunction

  function automatic void add(input bit r, input bit [3:0] rq, input bit [3:0] la, input bit [3:0] di,
                              input bit [3:0] g, input bit o, input bit v, input bit b, input bit t);
    tbl[n_tbl] = '{r, rq, la, di, g, o, v, b, t};
    n_tbl++;
  endfunction

  task automatic drive(input bit r, input logic [3:0] rq, input logic [3:0] la, input logic [3:0] di);
    rst_n = r; bus.req = rq; bus.last = la; bus.din = di;
  endtask

  initial begin
    logic [3:0] rq;
    drive(0, '0, '0, '0);
    step();

    // Single owner with last in 3rd grant cycle
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 0, 0, 1, 0);
    add(1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1, 1, 1, 0);
    add(1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1, 1, 1, 0);
    add(1, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1, 1, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    // Owner 3 releases with req=1001: pointer wraps, requester 0 wins
    add(1, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 0, 0, 1, 0);
    add(1, 4'b1001, 4'b1000, 4'b0000, 4'b0001, 0, 1, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 1, 0, 0);
    // Owner 2 held to HOLD_MAX with foreign last/din, then last at the limit
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++)
      add(1, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 0, 1, 1, 0);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 1, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0);
    // Reset mid-ownership, then pointer back at 0
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 0, 1, 0);
    add(1, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 1, 1, 0);
    add(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b0110, 4'b0000, 4'b0000, 4'b0010, 0, 0, 1, 0);

    for (int i = 0; i < n_tbl; i++) begin
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].last, tbl[i].din);
      step();
      check("table", i, dut_out(),
            {tbl[i].gnt, tbl[i].o, tbl[i].vld, tbl[i].busy, tbl[i].to});
      $display("table[%0d] req=%b last=%b din=%b -> gnt=%b o=%b vld=%b to=%b",
               i, tbl[i].req, tbl[i].last, tbl[i].din, bus.gnt, bus.o, bus.o_vld, bus.timeout);
    end

    // Sole requester, no last: HOLD_MAX grant cycles, timeout pulse, re-grant
    drive(0, '0, '0, '0); step();
    drive(1, 4'b0001, '0, '0);
    for (int k = 1; k <= 26; k++) begin
      step();
      check("hold_gnt", k, {4'b0, bus.gnt}, 8'b0000_0001);
      check("hold_to", k, {7'b0, bus.timeout}, {7'b0, (k > 1) && ((k - 1) % HM == 0)});
      $display("hold cycle %0d gnt=%b timeout=%b", k, bus.gnt, bus.timeout);
    end

    // All requesting, last every 2nd grant cycle: 0,1,2,3,0 with no bubbles
    drive(0, '0, '0, '0); step();
    drive(1, 4'b1111, '0, '0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("rr_gnt", k, {4'b0, bus.gnt}, {4'b0, 4'(1 << (((k - 1) / 2) % 4))});
      $display("rr cycle %0d gnt=%b busy=%b", k, bus.gnt, bus.busy);
      bus.last = (k % 2 == 0) ? 4'b1111 : 4'b0000;
    end

    // Randomized traffic against the reference model
    drive(0, '0, '0, '0); step();
    rq = '0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 9) == 0) rq[k] = ~rq[k];
      drive($urandom_range(0, 99) != 0, rq,
            ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
            4'($urandom_range(0, 15)));
      step();
      check("rand", c, dut_out(), {e_gnt, e_o, e_vld, (m_owner >= 0), e_to});
      $display("rand %0d rst_n=%b req=%b last=%b -> gnt=%b o=%b vld=%b to=%b",
               c, rst_n, bus.req, bus.last, bus.gnt, bus.o, bus.o_vld, bus.timeout);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
